// File: rtl/ext_rr_arbiter_ipa.sv
// ext_rr_arbiter_ipa: round-robin arbiter sharing one valid/ready sink among NB_REQ requesters; EXT_ARB_LOCK_EN enables burst locking
module ext_rr_arbiter_ipa #(
  parameter int NB_REQ     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LOG_NB_REQ = $clog2(NB_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NB_REQ-1:0]            req_valid_i,
  input  logic [NB_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NB_REQ-1:0]            req_last_i,
  output logic [NB_REQ-1:0]            req_ready_o,
  output logic                         valid_o,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         last_o,
  input  logic                         ready_i,
  output logic [LOG_NB_REQ-1:0]        grant_id_o,
  output logic                         locked_o
);
  localparam int CW = $clog2(MAX_BURST) + 1;
`ifdef EXT_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, HOLD, LOCKED} state_t;
  state_t                state, state_n;
  logic [LOG_NB_REQ-1:0] rr_ptr, rr_ptr_n, hold_id, hold_id_n, lock_id, lock_id_n, sel, scan_id;
  logic [LOG_NB_REQ:0]   idx;
  logic [CW-1:0]         beat_cnt, beat_cnt_n;
  logic                  xfer;

  function automatic logic [LOG_NB_REQ-1:0] wrap_inc(input logic [LOG_NB_REQ-1:0] id);
    return (id == LOG_NB_REQ'(NB_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  // first valid requester at or after rr_ptr; scanning downward lets the nearest one win
  always_comb begin
    scan_id = rr_ptr;
    idx     = '0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (LOG_NB_REQ + 1)'(i);
      if (idx >= (LOG_NB_REQ + 1)'(NB_REQ)) idx = idx - (LOG_NB_REQ + 1)'(NB_REQ);
      if (req_valid_i[idx[LOG_NB_REQ-1:0]]) scan_id = idx[LOG_NB_REQ-1:0];
    end
  end

  assign sel        = (state == HOLD) ? hold_id : (state == LOCKED) ? lock_id : scan_id;
  assign valid_o    = req_valid_i[sel];
  assign data_o     = req_data_i[sel*DATA_WIDTH +: DATA_WIDTH];
  assign last_o     = req_last_i[sel];
  assign grant_id_o = sel;
  assign locked_o   = LOCK_EN & (state == LOCKED);
  assign xfer       = valid_o & ready_i;

  // sink ready is routed back only to the selected requester
  always_comb begin
    req_ready_o      = '0;
    req_ready_o[sel] = ready_i;
  end

  // next state: lock on an unterminated first beat, hold on stall, else rotate on transfer
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    hold_id_n  = hold_id;
    lock_id_n  = lock_id;
    beat_cnt_n = beat_cnt;
    if (state == LOCKED) begin
      if (xfer && (last_o || beat_cnt == CW'(MAX_BURST - 1))) begin
        state_n    = IDLE;
        rr_ptr_n   = wrap_inc(lock_id);
        beat_cnt_n = '0;
      end else if (xfer) begin
        beat_cnt_n = beat_cnt + 1'b1;
      end
    end else if (xfer && LOCK_EN && !last_o) begin
      state_n    = LOCKED;
      lock_id_n  = sel;
      beat_cnt_n = CW'(1);
    end else if (xfer) begin
      state_n  = IDLE;
      rr_ptr_n = wrap_inc(sel);
    end else if (valid_o) begin
      state_n   = HOLD;
      hold_id_n = sel;
    end else begin
      state_n = IDLE;
    end
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      hold_id  <= '0;
      lock_id  <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      hold_id  <= hold_id_n;
      lock_id  <= lock_id_n;
      beat_cnt <= beat_cnt_n;
    end
  end
endmodule
